// File: rtl/refresh_scheduler_if.sv
// rtl/refresh_scheduler_if.sv - user-access and refresh-sequencer signal bundle
//
// Purpose: groups the user access strobes, the per-bank refresh handshake and
//          the scheduler status outputs into one bundle.
// Ports (signals):
//   u_we, u_re         user write/read enable
//   u_wbank, u_rbank   user write/read bank select
//   ref_done[7:0]      per-bank refresh-complete level
//   ref_start[7:0]     one-hot refresh start pulse
//   ref_active[7:0]    one-hot bank-under-refresh level
//   user_stall         user access collides with the bank under refresh
//   ref_ptr[2:0]       next or current bank to refresh
//   ref_overrun        sticky period overrun flag
//   ref_timeout        sticky done-timeout flag
// Modports: master = user/sequencer side, slave = scheduler.
interface refresh_scheduler_if;
  logic       u_we;
  logic       u_re;
  logic [2:0] u_wbank;
  logic [2:0] u_rbank;
  logic [7:0] ref_done;
  logic [7:0] ref_start;
  logic [7:0] ref_active;
  logic       user_stall;
  logic [2:0] ref_ptr;
  logic       ref_overrun;
  logic       ref_timeout;

  modport master (
    output u_we, u_re, u_wbank, u_rbank, ref_done,
    input  ref_start, ref_active, user_stall, ref_ptr, ref_overrun, ref_timeout
  );

  modport slave (
    input  u_we, u_re, u_wbank, u_rbank, ref_done,
    output ref_start, ref_active, user_stall, ref_ptr, ref_overrun, ref_timeout
  );
endinterface

// File: rtl/refresh_scheduler.sv
// rtl/refresh_scheduler.sv - round-robin 8-bank refresh scheduler
//
// Purpose: issues one bank refresh every REF_PERIOD cycles, walking the banks
//          0..7 in order, deferring a start up to DEFER_MAX cycles while a
//          user access targets the bank, and waiting for that bank's done.
// Ports:
//   clk   sole clock, rising edge
//   rst   asynchronous active-low reset
//   bus   refresh_scheduler_if.slave (user strobes, ref_done in; ref_start,
//         ref_active, user_stall, ref_ptr, ref_overrun, ref_timeout out)
// Optional feature: define REF_TIMEOUT_EN to bound the BUSY wait to TIMEOUT
//          cycles and drive ref_timeout; undefined, BUSY waits indefinitely
//          and ref_timeout is tied low.
module refresh_scheduler #(
  parameter int REF_PERIOD = 4055,
  parameter int DEFER_MAX  = 8,
  parameter int TIMEOUT    = 255
) (
  input logic               clk,
  input logic               rst,
  refresh_scheduler_if.slave bus
);

  localparam int PW = (REF_PERIOD < 2) ? 1 : $clog2(REF_PERIOD);
  localparam int DW = (DEFER_MAX < 1) ? 1 : $clog2(DEFER_MAX + 1);

  typedef enum logic [2:0] {IDLE, ARM, START, BUSY, ADV} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] period_cnt;
  logic [DW-1:0] defer_cnt;
  logic          pending;
  logic          overrun;
  logic [2:0]    ptr;
  logic [7:0]    done_q;
  logic          tc;
  logic          conflict;
  logic          done_rise;
  logic          defer_full;
  logic          to_hit;

  assign tc         = (period_cnt == PW'(REF_PERIOD - 1));
  assign conflict   = (bus.u_we && (bus.u_wbank == ptr)) ||
                      (bus.u_re && (bus.u_rbank == ptr));
  // History clears to 0 on reset, so a level already high at release looks
  // like an edge; it is harmless because only BUSY acts on it.
  assign done_rise  = bus.ref_done[ptr] & ~done_q[ptr];
  assign defer_full = (defer_cnt == DW'(DEFER_MAX));

`ifdef REF_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  logic [TW-1:0] to_cnt;
  logic          timeout_q;

  // Fires on the BUSY cycle whose increment would reach TIMEOUT, so BUSY
  // lasts at most TIMEOUT cycles.
  assign to_hit = (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (state == BUSY) begin
      if (to_hit) timeout_q <= 1'b1;
      to_cnt <= to_hit ? '0 : to_cnt + 1'b1;
    end else begin
      to_cnt <= '0;
    end
  end

  assign bus.ref_timeout = timeout_q;
`else
  assign to_hit          = 1'b0;
  assign bus.ref_timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      // The terminal count itself counts as a request so that ARM follows
      // the terminal-count cycle directly.
      IDLE:  if (pending || tc) state_nxt = ARM;
      ARM:   if (!conflict || defer_full) state_nxt = START;
      START: state_nxt = BUSY;
      BUSY:  if (done_rise || to_hit) state_nxt = ADV;
      ADV:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      period_cnt <= '0;
      defer_cnt  <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      ptr        <= 3'd0;
      done_q     <= 8'h00;
    end else begin
      state      <= state_nxt;
      period_cnt <= tc ? '0 : period_cnt + 1'b1;
      done_q     <= bus.ref_done;

      // START consumes the request; a terminal count in that same cycle
      // belongs to the next round.
      if (state == START) pending <= tc;
      else if (tc)        pending <= 1'b1;

      if (tc && pending && (state != START)) overrun <= 1'b1;

      if (state == START)                           defer_cnt <= '0;
      else if ((state == ARM) && (state_nxt == ARM)) defer_cnt <= defer_cnt + 1'b1;

      if (state == ADV) ptr <= ptr + 3'd1;
    end
  end

  assign bus.ref_start   = (state == START) ? (8'h01 << ptr) : 8'h00;
  assign bus.ref_active  = (state == BUSY)  ? (8'h01 << ptr) : 8'h00;
  assign bus.user_stall  = ((state == START) || (state == BUSY)) && conflict;
  assign bus.ref_ptr     = ptr;
  assign bus.ref_overrun = overrun;

endmodule

// File: tb/tb_refresh_scheduler.sv
// tb/tb_refresh_scheduler.sv - directed self-checking bench for refresh_scheduler
module tb_refresh_scheduler;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  refresh_scheduler_if bus();

  refresh_scheduler #(
    .REF_PERIOD(16),
    .DEFER_MAX (8),
    .TIMEOUT   (10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int cyc     = 0;
  int s       = 0;
  int prev    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic step_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic wait_start(input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (bus.ref_start != 8'h00) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_total++;
      n_fail++;
      $error("FAIL start_wait: no ref_start within %0d cycles", limit);
      at = cyc;
    end
  endtask

  // Entered on the START cycle; done arrives 3 cycles after start, with a
  // neighbouring bank's done pulsed first to show it is ignored.
  task automatic busy_done(input int bank);
    logic [7:0] oh;
    logic [2:0] b;
    logic [2:0] bn;
    oh = 8'h01 << bank;
    b  = 3'(bank);
    bn = 3'((bank + 1) % 8);
    step();
    check("busy_active", bus.ref_active, oh);
    check("start_one_cycle", bus.ref_start, 8'h00);
    step();
    bus.ref_done = 8'h01 << bn;
    step();
    check("other_done_ignored", bus.ref_active, oh);
    bus.ref_done = oh;
    step();
    check("adv_inactive", bus.ref_active, 8'h00);
    check("adv_ptr_hold", bus.ref_ptr, b);
    bus.ref_done = 8'h00;
    step();
    check("ptr_advanced", bus.ref_ptr, bn);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.u_we     = 1'b0;
    bus.u_re     = 1'b0;
    bus.u_wbank  = 3'd0;
    bus.u_rbank  = 3'd0;
    bus.ref_done = 8'hFF;

    // Reset state
    step(); step(); step();
    check("rst_start", bus.ref_start, 8'h00);
    check("rst_active", bus.ref_active, 8'h00);
    check("rst_ptr", bus.ref_ptr, 3'd0);
    check("rst_overrun", bus.ref_overrun, 1'b0);
    check("rst_timeout", bus.ref_timeout, 1'b0);
    check("rst_stall", bus.user_stall, 1'b0);

    // Release with done held high: no refresh activity results
    rst = 1'b1;
    cyc = 0;
    step();
    check("rel_active", bus.ref_active, 8'h00);
    check("rel_start", bus.ref_start, 8'h00);
    bus.ref_done = 8'h00;

    // Free run: banks 0..7 then 0, spaced 16 cycles
    for (int k = 0; k < 9; k++) begin
      wait_start(40, s);
      if (k == 0) check("first_start_cycle", s, 17);
      else        check("start_spacing", s - prev, 16);
      check("start_onehot", bus.ref_start, 8'h01 << (k % 8));
      busy_done(k % 8);
      prev = s;
    end

    // Conflict held for 3 ARM cycles on bank 1
    step_to(160);
    bus.u_we    = 1'b1;
    bus.u_wbank = 3'd1;
    for (int i = 0; i < 4; i++) begin
      check("arm_no_stall", bus.user_stall, 1'b0);
      check("arm_deferred", bus.ref_start, 8'h00);
      if (i < 3) step();
    end
    bus.u_we = 1'b0;
    wait_start(10, s);
    check("defer3_cycle", s, 164);
    check("defer3_onehot", bus.ref_start, 8'h02);
    busy_done(1);

    // Held read conflict on bank 2: start forced after DEFER_MAX
    step_to(176);
    bus.u_re    = 1'b1;
    bus.u_rbank = 3'd2;
    bus.u_we    = 1'b1;
    bus.u_wbank = 3'd5;
    for (int i = 0; i < 9; i++) begin
      check("held_arm_no_stall", bus.user_stall, 1'b0);
      check("held_arm_deferred", bus.ref_start, 8'h00);
      step();
    end
    check("held_start", bus.ref_start, 8'h04);
    check("held_stall_start", bus.user_stall, 1'b1);
    step();
    check("held_busy_active", bus.ref_active, 8'h04);
    check("held_stall_busy", bus.user_stall, 1'b1);
    step();
    check("held_stall_busy2", bus.user_stall, 1'b1);
    bus.u_re = 1'b0;
    bus.u_we = 1'b0;
    #1;
    check("stall_released", bus.user_stall, 1'b0);
    check("held_still_busy", bus.ref_active, 8'h04);
    step();
    bus.ref_done = 8'h04;
    step();
    check("held_adv", bus.ref_active, 8'h00);
    bus.ref_done = 8'h00;
    step();
    check("held_ptr", bus.ref_ptr, 3'd3);

    // Reset in the middle of BUSY on bank 3
    step_to(193);
    check("b3_start", bus.ref_start, 8'h08);
    step();
    check("b3_active", bus.ref_active, 8'h08);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_active", bus.ref_active, 8'h00);
    check("mid_rst_ptr", bus.ref_ptr, 3'd0);
    check("mid_rst_start", bus.ref_start, 8'h00);
    step();
    rst = 1'b1;
    cyc = 0;
    wait_start(40, s);
    check("post_rst_cycle", s, 17);
    check("post_rst_bank0", bus.ref_start, 8'h01);

`ifdef REF_TIMEOUT_EN
    // Done never arrives on bank 0
    step_to(27);
    check("to_not_yet", bus.ref_timeout, 1'b0);
    check("to_busy", bus.ref_active, 8'h01);
    step();
    check("to_flag", bus.ref_timeout, 1'b1);
    check("to_adv", bus.ref_active, 8'h00);
    step();
    check("to_ptr", bus.ref_ptr, 3'd1);
`else
    // Long BUSY so that the next START lands on a terminal count
    step_to(31);
    check("long_busy", bus.ref_active, 8'h01);
    step_to(43);
    check("long_busy2", bus.ref_active, 8'h01);
    bus.ref_done = 8'h01;
    step();
    check("long_adv", bus.ref_active, 8'h00);
    bus.ref_done = 8'h00;
    wait_start(10, s);
    check("coincide_cycle", s, 47);
    check("coincide_onehot", bus.ref_start, 8'h02);
    check("coincide_no_overrun", bus.ref_overrun, 1'b0);
    busy_done(1);
    wait_start(10, s);
    check("pending_kept_cycle", s, 54);
    check("pending_kept_onehot", bus.ref_start, 8'h04);
    check("pending_no_overrun", bus.ref_overrun, 1'b0);

    // Done withheld 40 cycles on bank 2
    step_to(79);
    check("ovr_not_yet", bus.ref_overrun, 1'b0);
    check("ovr_busy", bus.ref_active, 8'h04);
    step();
    check("ovr_flag", bus.ref_overrun, 1'b1);
    check("ovr_no_timeout", bus.ref_timeout, 1'b0);
    step_to(94);
    bus.ref_done = 8'h04;
    step();
    check("ovr_adv", bus.ref_active, 8'h00);
    bus.ref_done = 8'h00;
    wait_start(10, s);
    check("ovr_next_cycle", s, 98);
    check("ovr_next_onehot", bus.ref_start, 8'h08);
    check("ovr_sticky", bus.ref_overrun, 1'b1);
    check("ovr_timeout_low", bus.ref_timeout, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/refresh_scheduler.md
REFRESH_SCHEDULER -- requirements
Module: refresh_scheduler

Interface
REQ-001 Parameter REF_PERIOD, default 4055; cycles between refresh requests.
REQ-002 Parameter DEFER_MAX, default 8; maximum cycles a refresh start is deferred for user access.
REQ-003 Parameter TIMEOUT, default 255; maximum BUSY cycles waiting for done.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 u_we  in  1  registered user write enable.
REQ-007 u_re  in  1  registered user read enable.
REQ-008 u_wbank  in  3  write bank select (waddr[9:7]).
REQ-009 u_rbank  in  3  read bank select (raddr[9:7]).
REQ-010 ref_done  in  8  per-bank refresh-complete level from the bank shift-register sequencers.
REQ-011 ref_start  out  8  one-hot, one-cycle refresh start pulse.
REQ-012 ref_active  out  8  one-hot level, high while the bank is being refreshed.
REQ-013 user_stall  out  1  user access collides with the bank under refresh.
REQ-014 ref_ptr  out  3  next or current bank to refresh.
REQ-015 ref_overrun  out  1  sticky, period elapsed while a request was still pending.
REQ-016 ref_timeout  out  1  sticky, done not seen within TIMEOUT.

Function
REQ-017 Period counter SHALL count 0..REF_PERIOD-1 and wrap; the terminal count SHALL set the sticky pending flag.
REQ-018 A terminal count while pending is already set SHALL set ref_overrun; the request is not queued twice.
REQ-019 FSM states: IDLE, ARM, START, BUSY, ADV.
REQ-020 IDLE: pending=1 -> ARM next cycle.
REQ-021 ARM, conflict defined as (u_we && u_wbank==ref_ptr) || (u_re && u_rbank==ref_ptr): on conflict, stay in ARM and increment the defer count; with no conflict, or with the defer count at DEFER_MAX, go to START.
REQ-022 Latency: terminal count in cycle T -> ARM in T+1 -> ref_start pulse in T+2 when there is no conflict.
REQ-023 START: ref_start[ref_ptr]=1 for exactly one cycle; clear pending and the defer count; go to BUSY.
REQ-024 BUSY: ref_active[ref_ptr]=1; the timeout counter increments each cycle.
REQ-025 BUSY exit: a rising edge of ref_done[ref_ptr] (internal edge detector) SHALL go to ADV; ref_done of other banks SHALL be ignored.
REQ-026 BUSY exit: the timeout counter reaching TIMEOUT SHALL set ref_timeout and go to ADV.
REQ-027 ADV: ref_ptr = ref_ptr+1 modulo 8 (7 -> 0); go to IDLE.
REQ-028 user_stall SHALL be asserted combinationally when in START or BUSY and the conflict condition against ref_ptr is true.
REQ-029 user_stall SHALL be 0 in IDLE and ARM.
REQ-030 The period counter SHALL free-run in all FSM states.
REQ-031 A terminal count coinciding with START SHALL leave pending set for the next round and SHALL NOT flag overrun.
REQ-032 ref_done asserted high at reset release SHALL NOT produce an edge; the edge-detector history resets to 0, but the pulse is masked unless in BUSY.

Reset
REQ-033 rst low SHALL asynchronously force: FSM to IDLE; period, defer and timeout counters to 0; pending=0; ref_ptr=0; ref_start=0; ref_active=0; ref_overrun=0; ref_timeout=0; edge history=0.
REQ-034 Reset during BUSY SHALL drop ref_active immediately; no ADV and no pointer increment occur.
REQ-035 The first terminal count after release SHALL occur REF_PERIOD cycles after the first active clock edge.

Configuration
REQ-036 Macro REF_TIMEOUT_EN: when defined, REQ-026 and ref_timeout SHALL be implemented as specified.
REQ-037 When REF_TIMEOUT_EN is undefined, BUSY SHALL wait indefinitely for done, ref_timeout SHALL be tied to 0, and no timeout counter SHALL be synthesized.

Verification
REQ-038 Free run, REF_PERIOD=16, no user traffic, done pulsed 3 cycles after start -> ref_start cycles 0x01,0x02,...,0x80,0x01, spaced 16 cycles.
REQ-039 Conflict: u_we=1, u_wbank=ref_ptr held 3 cycles during ARM -> ref_start delayed 3 cycles, user_stall=0 throughout ARM.
REQ-040 Held conflict with DEFER_MAX=8 -> ref_start after 8 deferred cycles; user_stall=1 from START through BUSY.
REQ-041 Timeout with macro defined and TIMEOUT=10, ref_done never asserted -> ref_timeout=1 eleven cycles after start; ref_ptr advances.
REQ-042 Overrun: REF_PERIOD=16, done withheld 40 cycles with macro undefined -> ref_overrun=1; ref_timeout stays 0.
REQ-043 Reset: rst low mid-BUSY on bank 3 -> ref_active=0x00 and ref_ptr=0 immediately; next start at bank 0.
